// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract. WIDTH-bit operands are summed
// CHUNK bits per clock through one CHUNK-bit ripple stage, with the carry
// held in a register between chunks. start/ready/done handshake.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;     // opb already inverted for subtract
  logic             carry;
  logic [IW-1:0]    idx;
  int               base;
  logic [CHUNK-1:0] ca, cb, s;
  logic             c;
  logic             last;

  // One CHUNK-bit ripple slice over the currently selected chunk
  always_comb begin
    base      = int'(idx) * CHUNK;
    ca        = opa[base +: CHUNK];
    cb        = opb[base +: CHUNK];
    {c, s}    = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    last      = (idx == LAST);
  end

  // State register; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs (both decoded from registered state)
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation and final flags
  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opa   <= a;
          opb   <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          idx   <= '0;
        end
        RUN: begin
          sum[base +: CHUNK] <= s;
          carry              <= c;
          idx                <= last ? '0 : idx + IW'(1);
          if (last) begin
            cout <= c;
            // same-sign operands producing a result of the other sign
            ovf  <= (opa[WIDTH-1] == opb[WIDTH-1]) && (s[CHUNK-1] != opa[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: directed cases, handshake/reset timing and a
// randomized run against an arithmetic reference model.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst, start, cin, sub;
  logic [15:0] a, b, sum;
  logic        ready, done, cout, ovf;

  logic        s32, c32, r32, d32, co32, ov32;
  logic [31:0] a32, b32, sum32;
  logic        s8, c8, r8, d8, co8, ov8;
  logic [7:0]  a8, b8, sum8;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .start(s32), .a(a32), .b(b32), .cin(c32), .sub(1'b0),
    .ready(r32), .done(d32), .sum(sum32), .cout(co32), .ovf(ov32));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8), .sub(1'b0),
    .ready(r8), .done(d8), .sum(sum8), .cout(co8), .ovf(ov8));

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  task automatic model(input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input logic s, output logic [15:0] r, output logic co,
                       output logic ov);
    int ux, uy, sx, sy, tu, ts;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      tu = ux - uy;
      co = (ux >= uy);
      ts = sx - sy;
    end else begin
      tu = ux + uy + int'(ci);
      co = (tu > 65535);
      ts = sx + sy + int'(ci);
    end
    r  = 16'(tu);
    ov = (ts > 32767) || (ts < -32768);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready_timeout"}, 64'(ready), 64'd1);
  endtask

  // One full operation: accept, scramble inputs, measure latency, check result
  task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic s, input logic [15:0] er,
                       input logic eco, input logic eov);
    int k;
    wait_ready(tag);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    step();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    k = 1;
    while (!done && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'd5);
    chk({tag, "_sum"}, 64'(sum), 64'(er));
    chk({tag, "_cout"}, 64'(cout), 64'(eco));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eov));
    chk({tag, "_ready_in_done"}, 64'(ready), 64'd0);
    step();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_ready_after"}, 64'(ready), 64'd1);
  endtask

  initial begin
    logic [15:0] rx, ry, er;
    logic        rci, rs, eco, eov;
    int          nd, k;
    int          dq[$];
    logic [8:0]  e8;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0;
    s8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // start during reset is dropped
    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h1111;
    step(); step();
    rst = 1'b0; start = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || !ready) nd++;
      step();
    end
    chk("rst_start_dropped", 64'(nd), 64'd0);
    chk("rst_start_sum", 64'(sum), 64'd0);

    // Directed arithmetic
    do_op("add1",   16'hFF3F, 16'h5555, 1'b0, 1'b0, 16'h5494, 1'b1, 1'b0);
    do_op("add2",   16'hCF39, 16'h30C6, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("ovf1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf2",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("sub1",   16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub2",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Second start at T+2 is ignored; only one done pulse
    wait_ready("ign");
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();                       // cycle T+1
    start = 1'b0;
    step();                       // cycle T+2
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    step();
    start = 1'b0;
    nd = 0;
    for (k = 3; k <= 10; k++) begin
      if (done) begin
        nd++;
        chk("ign_done_cycle", 64'(k), 64'd5);
        chk("ign_sum", 64'(sum), 64'h2345);
      end
      step();
    end
    chk("ign_one_done", 64'(nd), 64'd1);

    // start held high: back-to-back every NCHUNK+2 cycles
    wait_ready("hold");
    a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    for (k = 1; k <= 17; k++) begin
      if (done) dq.push_back(k);
      step();
    end
    start = 1'b0;
    chk("hold_count", 64'(dq.size()), 64'd3);
    if (dq.size() == 3) begin
      chk("hold_d0", 64'(dq[0]), 64'd5);
      chk("hold_d1", 64'(dq[1]), 64'd11);
      chk("hold_d2", 64'(dq[2]), 64'd17);
    end
    chk("hold_sum", 64'(sum), 64'h0406);

    // Reset mid-operation aborts without a done pulse
    wait_ready("abort");
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();                       // T+1
    start = 1'b0;
    nd = int'(done);
    step();                       // T+2
    nd += int'(done);
    rst = 1'b1;
    step();                       // T+3
    rst = 1'b0;
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_cout", 64'(cout), 64'd0);
    for (int i = 0; i < 8; i++) begin
      nd += int'(done);
      step();
    end
    chk("abort_no_done", 64'(nd), 64'd0);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      if (i % 5 == 0) ry = rx;
      rci = 1'($urandom); rs = 1'($urandom);
      model(rx, ry, rci, rs, er, eco, eov);
      do_op($sformatf("rnd%0d", i), rx, ry, rci, rs, er, eco, eov);
    end

    // WIDTH=32, CHUNK=8 instance
    a32 = 32'hFFFFFFFF; b32 = 32'h0; c32 = 1'b1; s32 = 1'b1;
    chk("w32_ready", 64'(r32), 64'd1);
    step();
    s32 = 1'b0; a32 = 32'h5; c32 = 1'b0;
    k = 1;
    while (!d32 && k < 20) begin
      step();
      k++;
    end
    chk("w32_latency", 64'(k), 64'd5);
    chk("w32_sum", 64'(sum32), 64'd0);
    chk("w32_cout", 64'(co32), 64'd1);
    chk("w32_ovf", 64'(ov32), 64'd0);

    // WIDTH=8, CHUNK=8 instance: single compute cycle
    for (int i = 0; i < 4; i++) begin
      step();
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      e8 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      chk("w8_ready", 64'(r8), 64'd1);
      s8 = 1'b1;
      step();
      s8 = 1'b0; a8 = ~a8;
      k = 1;
      while (!d8 && k < 20) begin
        step();
        k++;
      end
      chk("w8_latency", 64'(k), 64'd2);
      chk("w8_sum", 64'(sum8), 64'(e8[7:0]));
      chk("w8_cout", 64'(co8), 64'(e8[8]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
